// File: rtl/sensor_timing_gen_if.sv
// Bundle of the timing generator's control input and timing outputs.
// Ports:
//   i_acq_start   acquisition enable level (sink -> generator)
//   o_fval        frame valid
//   o_lval        line valid
//   o_frame_done  one-cycle pulse when o_fval falls
//   ov_line_cnt   current line index
//   ov_frame_cnt  completed frame count
//   ov_pattern    test pattern, aligned with o_lval
//   master = generator side, slave = consumer side.
interface sensor_timing_gen_if #(
  parameter int CNT_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  i_acq_start;
  logic                  o_fval;
  logic                  o_lval;
  logic                  o_frame_done;
  logic [CNT_WIDTH-1:0]  ov_line_cnt;
  logic [CNT_WIDTH-1:0]  ov_frame_cnt;
  logic [DATA_WIDTH-1:0] ov_pattern;

  modport master (
    input  i_acq_start,
    output o_fval, o_lval, o_frame_done, ov_line_cnt, ov_frame_cnt, ov_pattern
  );

  modport slave (
    output i_acq_start,
    input  o_fval, o_lval, o_frame_done, ov_line_cnt, ov_frame_cnt, ov_pattern
  );
endinterface

// File: rtl/sensor_timing_gen.sv
// Frame/line (fval/lval) timing generator for the sensor simulation path.
// Latency: all outputs registered; fval rises 1 clk after i_acq_start is seen in IDLE.
// Backpressure: none; free-running once started, stops only on a frame boundary.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   tg     sensor_timing_gen_if.master (acq_start in; fval/lval/frame_done,
//          line/frame counters and pattern out)
// Optional feature: define TIMING_GEN_PATTERN_EN to build the (line + pixel)
// test pattern; otherwise ov_pattern is tied to 0.
module sensor_timing_gen #(
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 16,
  parameter int H_BLANK      = 16,
  parameter int V_FRONT      = 8,
  parameter int V_BACK       = 8,
  parameter int FRAME_GAP    = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  sensor_timing_gen_if.master tg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FRONT  = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
    S_BACK   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] FRONT_LAST  = CNT_WIDTH'(V_FRONT - 1);
  localparam logic [CNT_WIDTH-1:0] WIDTH_LAST  = CNT_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] HEIGHT_LAST = CNT_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] HBLANK_LAST = CNT_WIDTH'(H_BLANK - 1);
  localparam logic [CNT_WIDTH-1:0] BACK_LAST   = CNT_WIDTH'(V_BACK - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(FRAME_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] line_q, line_d;
  logic [CNT_WIDTH-1:0] frame_q, frame_d;
  logic                 fval_q, fval_d;
  logic                 lval_q, lval_d;
  logic                 done_q, done_d;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  // Next state. cnt restarts at 0 on every state change; i_acq_start only
  // matters in IDLE and on the final cycle of BACK/GAP so frames never truncate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    line_d  = line_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tg.i_acq_start) begin
          state_d = S_FRONT;
          line_d  = '0;
        end
      end
      S_FRONT: begin
        if (cnt_q == FRONT_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_LINE: begin
        if (cnt_q == WIDTH_LAST) begin
          cnt_d   = '0;
          state_d = (line_q == HEIGHT_LAST) ? S_BACK : S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HBLANK_LAST) begin
          state_d = S_LINE;
          cnt_d   = '0;
          line_d  = line_q + ONE;
        end
      end
      S_BACK: begin
        if (cnt_q == BACK_LAST) begin
          cnt_d   = '0;
          frame_d = frame_q + ONE;
          state_d = tg.i_acq_start ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (tg.i_acq_start) begin
            state_d = S_FRONT;
            line_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the state being entered, so the registered outputs
  // change on the same edge that enters the state.
  always_comb begin
    fval_d = (state_d == S_FRONT) || (state_d == S_LINE) ||
             (state_d == S_HBLANK) || (state_d == S_BACK);
    lval_d = (state_d == S_LINE);
    done_d = (state_q == S_BACK) && (state_d != S_BACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fval_q <= fval_d;
      lval_q <= lval_d;
      done_q <= done_d;
    end
  end

`ifdef TIMING_GEN_PATTERN_EN
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;

  // In LINE, cnt is the pixel index; the sum wraps mod 2^DATA_WIDTH.
  always_comb begin
    pattern_d = '0;
    if (lval_d) begin
      pattern_d = DATA_WIDTH'(line_d) + DATA_WIDTH'(cnt_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= '0;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  assign tg.ov_pattern = pattern_q;
`else
  assign tg.ov_pattern = '0;
`endif

  assign tg.o_fval       = fval_q;
  assign tg.o_lval       = lval_q;
  assign tg.o_frame_done = done_q;
  assign tg.ov_line_cnt  = line_q;
  assign tg.ov_frame_cnt = frame_q;

endmodule

// File: tb/tb_sensor_timing_gen.sv
// Bench for sensor_timing_gen: a default-geometry instance driven with random
// acq_start levels plus directed start/drop/reset scenarios, and a small
// CNT_WIDTH=4 instance left running to exercise frame counter wrap.
module tb_sensor_timing_gen;

  typedef struct {
    int vf; int w; int h; int hb; int vb; int gap; int cw; int dw;
  } geom_t;

  // mode: 0 = stopped, 1 = inside a frame (fval high), 2 = inter-frame gap
  typedef struct {
    int mode; int t; int frames; int line; bit done;
  } mstate_t;

  typedef struct {
    bit fval; bit lval; bit done; int line; int frame; int pat;
  } exp_t;

  logic clk;
  logic rst0, rst1;

  sensor_timing_gen_if #(.CNT_WIDTH(16), .DATA_WIDTH(8)) if0 ();
  sensor_timing_gen_if #(.CNT_WIDTH(4),  .DATA_WIDTH(8)) if1 ();

  sensor_timing_gen #(
    .IMAGE_WIDTH(64), .IMAGE_HEIGHT(16), .H_BLANK(16), .V_FRONT(8),
    .V_BACK(8), .FRAME_GAP(32), .CNT_WIDTH(16), .DATA_WIDTH(8)
  ) dut0 (.clk(clk), .reset(rst0), .tg(if0));

  sensor_timing_gen #(
    .IMAGE_WIDTH(5), .IMAGE_HEIGHT(3), .H_BLANK(2), .V_FRONT(2),
    .V_BACK(3), .FRAME_GAP(1), .CNT_WIDTH(4), .DATA_WIDTH(8)
  ) dut1 (.clk(clk), .reset(rst1), .tg(if1));

  geom_t g0 = '{vf:8, w:64, h:16, hb:16, vb:8, gap:32, cw:16, dw:8};
  geom_t g1 = '{vf:2, w:5,  h:3,  hb:2,  vb:3, gap:1,  cw:4,  dw:8};

  mstate_t m0, m1;
  exp_t    q0[$];
  exp_t    q1[$];
  int      n_cmp = 0;
  int      n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (frame-level arithmetic) ----------------
  function automatic int body_len(geom_t g);
    return g.h * g.w + (g.h - 1) * g.hb;
  endfunction

  function automatic int frame_len(geom_t g);
    return g.vf + body_len(g) + g.vb;
  endfunction

  function automatic void mstep(inout mstate_t m, input bit acq, input geom_t g);
    int u;
    m.done = 1'b0;
    case (m.mode)
      0: if (acq) begin m.mode = 1; m.t = 0; m.line = 0; end
      1: begin
        if (m.t == frame_len(g) - 1) begin
          m.frames++;
          m.done = 1'b1;
          if (acq) begin m.mode = 2; m.t = 0; end
          else m.mode = 0;
        end else begin
          m.t++;
        end
      end
      default: begin
        if (m.t == g.gap - 1) begin
          if (acq) begin m.mode = 1; m.t = 0; m.line = 0; end
          else m.mode = 0;
        end else begin
          m.t++;
        end
      end
    endcase
    if (m.mode == 1 && m.t >= g.vf) begin
      u = m.t - g.vf;
      if (u < body_len(g)) m.line = u / (g.w + g.hb);
      else                 m.line = g.h - 1;
    end
  endfunction

  function automatic exp_t mexp(mstate_t m, geom_t g);
    exp_t e;
    int   u, pos;
    e.fval  = (m.mode == 1);
    e.lval  = 1'b0;
    e.done  = m.done;
    e.line  = m.line  % (1 << g.cw);
    e.frame = m.frames % (1 << g.cw);
    e.pat   = 0;
    if (m.mode == 1 && m.t >= g.vf) begin
      u   = m.t - g.vf;
      pos = u % (g.w + g.hb);
      if (u < body_len(g) && pos < g.w) begin
        e.lval = 1'b1;
`ifdef TIMING_GEN_PATTERN_EN
        e.pat = (m.line + pos) % (1 << g.dw);
`endif
      end
    end
    return e;
  endfunction

  // Model advances on every edge and queues what each DUT must show after it.
  always @(posedge clk) begin
    if (rst0) m0 = '{default: 0};
    else      mstep(m0, if0.i_acq_start, g0);
    q0.push_back(mexp(m0, g0));
    if (rst1) m1 = '{default: 0};
    else      mstep(m1, if1.i_acq_start, g1);
    q1.push_back(mexp(m1, g1));
  end

  // ---------------- checking ----------------
  task automatic chk_out(string nm, exp_t e, int f, int l, int d, int ln, int fr, int pt);
    n_cmp++;
    if (f != int'(e.fval) || l != int'(e.lval) || d != int'(e.done) ||
        ln != e.line || fr != e.frame || pt != e.pat) begin
      n_err++;
      $display("FAIL %s t=%0t got fval=%0d lval=%0d done=%0d line=%0d frame=%0d pat=%0d want fval=%0d lval=%0d done=%0d line=%0d frame=%0d pat=%0d",
               nm, $time, f, l, d, ln, fr, pt,
               e.fval, e.lval, e.done, e.line, e.frame, e.pat);
    end
  endtask

  task automatic chk_val(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() == 0) begin
      chk_val("dut0_queue_empty", 0, 1);
    end else begin
      e = q0.pop_front();
      chk_out("dut0_outputs", e, int'(if0.o_fval), int'(if0.o_lval),
              int'(if0.o_frame_done), int'(if0.ov_line_cnt),
              int'(if0.ov_frame_cnt), int'(if0.ov_pattern));
    end
    if (q1.size() == 0) begin
      chk_val("dut1_queue_empty", 0, 1);
    end else begin
      e = q1.pop_front();
      chk_out("dut1_outputs", e, int'(if1.o_fval), int'(if1.o_lval),
              int'(if1.o_frame_done), int'(if1.ov_line_cnt),
              int'(if1.ov_frame_cnt), int'(if1.ov_pattern));
    end
  end

  // Stimulus changes 2 time units after the falling edge, clear of both the
  // sampling edge and the monitor.
  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.i_acq_start = 1'b0;
    if1.i_acq_start = 1'b0;
    wait_cyc(3);
    chk_val("reset_fval",  int'(if0.o_fval), 0);
    chk_val("reset_lval",  int'(if0.o_lval), 0);
    chk_val("reset_frame", int'(if0.ov_frame_cnt), 0);
    chk_val("reset_line",  int'(if0.ov_line_cnt), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    if1.i_acq_start = 1'b1;

    // Start from IDLE: fval 1 clk later, first lval 8 clk after that.
    wait_cyc($urandom_range(2, 10));
    if0.i_acq_start = 1'b1;
    wait_cyc(1);
    chk_val("start_fval_rise", int'(if0.o_fval), 1);
    chk_val("start_lval_low",  int'(if0.o_lval), 0);
    wait_cyc(7);
    chk_val("front_lval_low",  int'(if0.o_lval), 0);
    wait_cyc(1);
    chk_val("first_lval_rise", int'(if0.o_lval), 1);

    // Three back-to-back frames.
    wait_cyc(3 * 1312 + 40);

    // Random acq_start levels and hold times.
    for (int s = 0; s < 12; s++) begin
      if0.i_acq_start = 1'($urandom_range(0, 1));
      wait_cyc($urandom_range(1, 2600));
    end

    // Drop acq_start during line 5: frame must complete, then stay idle.
    if0.i_acq_start = 1'b0;
    wait_cyc(2 * 1312);
    if0.i_acq_start = 1'b1;
    wait_cyc(1 + 8 + 5 * 80 + 20);
    chk_val("line5_line_cnt", int'(if0.ov_line_cnt), 5);
    if0.i_acq_start = 1'b0;
    wait_cyc(1500);
    chk_val("after_drop_fval", int'(if0.o_fval), 0);

    // Reset during line 7: outputs drop without waiting for an edge.
    if0.i_acq_start = 1'b1;
    wait_cyc(1 + 8 + 7 * 80 + 10);
    chk_val("line7_line_cnt", int'(if0.ov_line_cnt), 7);
    rst0 = 1'b1;
    #1;
    chk_val("async_rst_fval",  int'(if0.o_fval), 0);
    chk_val("async_rst_lval",  int'(if0.o_lval), 0);
    chk_val("async_rst_frame", int'(if0.ov_frame_cnt), 0);
    wait_cyc(3);
    rst0 = 1'b0;
    wait_cyc(2 * 1312);
    if0.i_acq_start = 1'b0;
    wait_cyc(1400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
